// File: rtl/i2s_dac_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_tx_if
// Description : Bundle between the delay effect stage, the I2S transmitter
//               and the audio DAC pins.
//               master : upstream side (drives in/valid, sees the I2S lines,
//                        the frame request tick and the underrun pulse)
//               slave  : transmitter side
// Signals     : in[SIG_BITS]  sample from the delay stage (two's complement)
//               valid         one-cycle strobe qualifying in
//               bclk          I2S bit clock
//               lrclk         I2S word select, 0 = left, 1 = right
//               sdata         I2S serial data, MSB first
//               frame_req     one-cycle pulse at the start of each frame
//               underrun      one-cycle pulse when a frame starts without
//                             a fresh sample
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_dac_tx_if #(
   parameter int SIG_BITS = 16
);
   logic [SIG_BITS-1:0] in;
   logic                valid;
   logic                bclk;
   logic                lrclk;
   logic                sdata;
   logic                frame_req;
   logic                underrun;

   modport master (
      output in, valid,
      input  bclk, lrclk, sdata, frame_req, underrun
   );

   modport slave (
      input  in, valid,
      output bclk, lrclk, sdata, frame_req, underrun
   );
endinterface
`default_nettype wire

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_tx
// Description : Serialises the mono output of the delay stage into an I2S
//               stream. The newest sample is held and sent on both channels
//               of every frame. A per-frame request pulse serves as the
//               sample-rate tick for upstream stages.
// Ports       : clk      system clock (50 MHz)
//               reset_n  asynchronous active-low reset
//               bus      i2s_dac_tx_if.slave (in/valid in, I2S lines,
//                        frame_req and underrun out; all outputs registered)
// Options     : I2S_DAC_UNDERRUN_MUTE_EN - when defined, a frame that starts
//               without a fresh sample transmits silence instead of
//               repeating the last sample.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_dac_tx #(
   parameter int SIG_BITS = 16,
   parameter int HALF_DIV = 8,
   parameter int SLOT_B   = 32
) (
   input  wire logic   clk,
   input  wire logic   reset_n,
   i2s_dac_tx_if.slave bus
);
   localparam int              c_DW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int              c_BW       = $clog2(2 * SLOT_B);
   localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(HALF_DIV - 1);
   localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(2 * SLOT_B - 1);
   localparam logic [c_BW-1:0] c_SLOT     = c_BW'(SLOT_B);
   localparam logic [c_BW-1:0] c_MSB_POS  = c_BW'(SIG_BITS);

   logic [c_DW-1:0]     r_div_cnt;
   logic [c_BW-1:0]     r_bit_cnt;
   logic                r_bclk;
   logic                r_lrclk;
   logic                r_sdata;
   logic                r_frame_req;
   logic                r_underrun;
   logic [SIG_BITS-1:0] r_hold;
   logic [SIG_BITS-1:0] r_frame_smp;
   logic [SIG_BITS-1:0] r_shift;
   logic                r_fresh;

   logic                w_wrap;
   logic                w_fall;
   logic                w_frame_start;
   logic [c_BW-1:0]     w_bit_nxt;
   logic [c_BW-1:0]     w_pos;
   logic                w_underrun;
   logic [SIG_BITS-1:0] w_smp_load;

   assign w_wrap        = (r_div_cnt == c_DIV_LAST);
   assign w_fall        = w_wrap & r_bclk;
   assign w_frame_start = w_fall & (r_bit_cnt == c_BIT_LAST);
   assign w_bit_nxt     = w_frame_start ? '0 : r_bit_cnt + c_BW'(1);
   // Position within the channel slot the new bit belongs to.
   assign w_pos         = (w_bit_nxt >= c_SLOT) ? w_bit_nxt - c_SLOT : w_bit_nxt;
   // A strobe landing in the frame-start cycle itself counts as fresh.
   assign w_underrun    = w_frame_start & ~r_fresh & ~bus.valid;

   // Sample latched for the frame about to start; a coincident strobe
   // bypasses the holding register.
   always_comb begin
      w_smp_load = r_hold;
      if (bus.valid) begin
         w_smp_load = bus.in;
      end
`ifdef I2S_DAC_UNDERRUN_MUTE_EN
      else if (w_underrun) begin
         w_smp_load = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div_cnt   <= '0;
         r_bit_cnt   <= c_BIT_LAST;
         r_bclk      <= 1'b0;
         r_lrclk     <= 1'b1;
         r_sdata     <= 1'b0;
         r_frame_req <= 1'b0;
         r_underrun  <= 1'b0;
         r_hold      <= '0;
         r_frame_smp <= '0;
         r_shift     <= '0;
         r_fresh     <= 1'b0;
      end else begin
         r_frame_req <= w_frame_start;
         r_underrun  <= w_underrun;

         if (w_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
         end else begin
            r_div_cnt <= r_div_cnt + c_DW'(1);
         end

         // Everything the DAC samples changes on the BCLK falling edge so
         // it is stable around the following rising edge.
         if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            if (w_bit_nxt == '0) begin
               r_lrclk <= 1'b0;
            end else if (w_bit_nxt == c_SLOT) begin
               r_lrclk <= 1'b1;
            end

            // Slot position 0 is the I2S one-bit delay after the LRCLK edge:
            // output a zero and arm the shifter with the slot's word. The
            // left slot takes the word being latched right now.
            if (w_pos == '0) begin
               r_sdata <= 1'b0;
               r_shift <= w_frame_start ? w_smp_load : r_frame_smp;
            end else if (w_pos <= c_MSB_POS) begin
               r_sdata <= r_shift[SIG_BITS-1];
               r_shift <= {r_shift[SIG_BITS-2:0], 1'b0};
            end else begin
               r_sdata <= 1'b0;
            end
         end

         if (bus.valid) begin
            r_hold <= bus.in;
         end

         if (w_frame_start) begin
            r_frame_smp <= w_smp_load;
            r_fresh     <= 1'b0;
         end else if (bus.valid) begin
            r_fresh <= 1'b1;
         end
      end
   end

   assign bus.bclk      = r_bclk;
   assign bus.lrclk     = r_lrclk;
   assign bus.sdata     = r_sdata;
   assign bus.frame_req = r_frame_req;
   assign bus.underrun  = r_underrun;

endmodule
`default_nettype wire
